// File: rtl/iob_ram_tdp_arbiter_pkg.sv
// Shared definitions for the true-dual-port RAM arbiter: requester index width
// helper and a slice-extraction macro for the packed requester buses.
`ifndef IOB_RAM_TDP_ARBITER_PKG_SV
`define IOB_RAM_TDP_ARBITER_PKG_SV

// Slice i (width w) of a packed per-requester bus.
`define IOB_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package iob_ram_tdp_arbiter_pkg;

   localparam int unsigned N_REQ_DEF  = 4;
   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;

   function automatic int unsigned req_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`endif

// File: rtl/iob_rr_pick.sv
// Finds the first set bit of mask_i at or after start_i, wrapping around.
module iob_rr_pick
   import iob_ram_tdp_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   localparam int unsigned REQ_W = req_w(N_REQ)
) (
   input  logic [N_REQ-1:0] mask_i,
   input  logic [REQ_W-1:0] start_i,
   output logic             found_o,
   output logic [REQ_W-1:0] idx_o
);

   logic [N_REQ-1:0] rot;
   int unsigned      pos;

   // Rotate so that bit 0 is the start position, then take the lowest set bit.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = 0;
      rot     = N_REQ'({mask_i, mask_i} >> start_i);
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!found_o && rot[k]) begin
            found_o = 1'b1;
            pos     = 32'(start_i) + k;
            idx_o   = (pos >= N_REQ) ? REQ_W'(pos - N_REQ) : REQ_W'(pos);
         end
      end
   end

endmodule

// File: rtl/iob_ram_tdp_arbiter.sv
// Round-robin arbiter sharing one true-dual-port RAM among N_REQ requesters:
// up to two grants per cycle (A then B), read data routed back one cycle later.
module iob_ram_tdp_arbiter
   import iob_ram_tdp_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   input  logic [N_REQ-1:0]          req_we_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
   output logic [N_REQ-1:0]          rsp_valid_o,
   output logic [N_REQ*DATA_W-1:0]   rsp_rdata_o,
   output logic                      enA_o,
   output logic                      weA_o,
   output logic [ADDR_W-1:0]         addrA_o,
   output logic [DATA_W-1:0]         dA_o,
   input  logic [DATA_W-1:0]         dA_i,
   output logic                      enB_o,
   output logic                      weB_o,
   output logic [ADDR_W-1:0]         addrB_o,
   output logic [DATA_W-1:0]         dB_o,
   input  logic [DATA_W-1:0]         dB_i
);

   localparam int unsigned      REQ_W    = req_w(N_REQ);
   localparam logic [REQ_W-1:0] LAST_IDX = REQ_W'(N_REQ - 1);

   logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  rsp_a_q, rsp_a_d;
   logic [N_REQ-1:0]  rsp_b_q, rsp_b_d;

   logic [N_REQ-1:0]  valid_m, mask_b;
   logic              found_a, found_b, grant_a, grant_b;
   logic [REQ_W-1:0]  g_a, g_b, start_b;
   logic              we_a, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wd_a, wd_b;

   // Grants are suppressed while reset is held.
   assign valid_m = req_valid_i & {N_REQ{arst_n_i}};
   assign start_b = (g_a == LAST_IDX) ? '0 : g_a + REQ_W'(1);
   assign mask_b  = valid_m & ~(N_REQ'(1) << g_a);

   iob_rr_pick #(.N_REQ(N_REQ)) u_pick_a (
      .mask_i  (valid_m),
      .start_i (rr_ptr_q),
      .found_o (found_a),
      .idx_o   (g_a)
   );

   iob_rr_pick #(.N_REQ(N_REQ)) u_pick_b (
      .mask_i  (mask_b),
      .start_i (start_b),
      .found_o (found_b),
      .idx_o   (g_b)
   );

   // Select the operands of the two candidate requesters.
   always_comb begin
      we_a   = 1'b0;
      addr_a = '0;
      wd_a   = '0;
      we_b   = 1'b0;
      addr_b = '0;
      wd_b   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (g_a == REQ_W'(i)) begin
            we_a   = req_we_i[i];
            addr_a = `IOB_SLICE(req_addr_i, i, ADDR_W);
            wd_a   = `IOB_SLICE(req_wdata_i, i, DATA_W);
         end
         if (g_b == REQ_W'(i)) begin
            we_b   = req_we_i[i];
            addr_b = `IOB_SLICE(req_addr_i, i, ADDR_W);
            wd_b   = `IOB_SLICE(req_wdata_i, i, DATA_W);
         end
      end
   end

   // Same address with any write involved: B waits so the two ports never collide.
   assign grant_a = found_a;
   assign grant_b = found_b & ~((addr_a == addr_b) & (we_a | we_b));

   assign req_ready_o = ({N_REQ{grant_a}} & (N_REQ'(1) << g_a))
                      | ({N_REQ{grant_b}} & (N_REQ'(1) << g_b));

   assign enA_o   = grant_a;
   assign weA_o   = grant_a & we_a;
   assign addrA_o = grant_a ? addr_a : '0;
   assign dA_o    = grant_a ? wd_a : '0;
   assign enB_o   = grant_b;
   assign weB_o   = grant_b & we_b;
   assign addrB_o = grant_b ? addr_b : '0;
   assign dB_o    = grant_b ? wd_b : '0;

   // Pointer moves past the last granted index; reads remember their owner.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      rsp_a_d  = '0;
      rsp_b_d  = '0;
      if (grant_b) begin
         rr_ptr_d = (g_b == LAST_IDX) ? '0 : g_b + REQ_W'(1);
      end else if (grant_a) begin
         rr_ptr_d = start_b;
      end
      if (grant_a && !we_a) rsp_a_d = N_REQ'(1) << g_a;
      if (grant_b && !we_b) rsp_b_d = N_REQ'(1) << g_b;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rr_ptr_q <= '0;
         rsp_a_q  <= '0;
         rsp_b_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rsp_a_q  <= rsp_a_d;
         rsp_b_q  <= rsp_b_d;
      end
   end

   assign rsp_valid_o = rsp_a_q | rsp_b_q;

   // RAM read data arrives the cycle after the grant; steer it to its owner.
   always_comb begin
      rsp_rdata_o = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (rsp_a_q[i]) begin
            `IOB_SLICE(rsp_rdata_o, i, DATA_W) = dA_i;
         end else if (rsp_b_q[i]) begin
            `IOB_SLICE(rsp_rdata_o, i, DATA_W) = dB_i;
         end
      end
   end

endmodule

// File: tb/tb_iob_ram_tdp_arbiter.sv
// Bench for iob_ram_tdp_arbiter: attached TDP RAM model, scan-order reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_iob_ram_tdp_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic            clk_i    = 1'b0;
   logic            arst_n_i = 1'b0;
   logic [N-1:0]    req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
   logic [N*AW-1:0] req_addr_i;
   logic [N*DW-1:0] req_wdata_i, rsp_rdata_o;
   logic            enA_o, weA_o, enB_o, weB_o;
   logic [AW-1:0]   addrA_o, addrB_o;
   logic [DW-1:0]   dA_o, dB_o;
   logic [DW-1:0]   dA_i = '0;
   logic [DW-1:0]   dB_i = '0;

   always #5 clk_i = ~clk_i;

   iob_ram_tdp_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .enA_o(enA_o), .weA_o(weA_o), .addrA_o(addrA_o), .dA_o(dA_o), .dA_i(dA_i),
      .enB_o(enB_o), .weB_o(weB_o), .addrB_o(addrB_o), .dB_o(dB_o), .dB_i(dB_i)
   );

   // Behavioural true-dual-port RAM, 1-cycle registered read.
   logic [DW-1:0] ram [16] = '{default: '0};
   always @(posedge clk_i) begin
      if (enA_o) begin
         if (weA_o) ram[addrA_o] <= dA_o;
         else       dA_i <= ram[addrA_o];
      end
      if (enB_o) begin
         if (weB_o) ram[addrB_o] <= dB_o;
         else       dB_i <= ram[addrB_o];
      end
   end

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int            m_rr = 0;
   logic [DW-1:0] m_mem [16] = '{default: '0};
   logic [N-1:0]  m_rsp_v = '0;
   logic [N*DW-1:0] m_rsp_d = '0;
   logic [N-1:0]  m_acc = '0;
   int            cnt [N];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] addr_of(input int i);
      return req_addr_i[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      return req_wdata_i[i*DW +: DW];
   endfunction

   task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
      req_valid_i[i]          = v;
      req_we_i[i]             = we;
      req_addr_i[i*AW +: AW]  = AW'(a);
      req_wdata_i[i*DW +: DW] = DW'(d);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
   endtask

   // Compare all outputs against the model at the falling edge, then advance the model.
   task automatic eval();
      int ga, gb;
      int order [$];
      logic [N-1:0]    e_rdy, n_v;
      logic [N*DW-1:0] n_d;
      @(negedge clk_i);
      ga = -1;
      gb = -1;
      if (arst_n_i) begin
         for (int k = 0; k < N; k++) begin
            if (req_valid_i[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
         end
      end
      if (order.size() > 0) ga = order[0];
      if (order.size() > 1) gb = order[1];
      if (gb >= 0) begin
         if (addr_of(ga) == addr_of(gb) && (req_we_i[ga] || req_we_i[gb])) gb = -1;
      end
      e_rdy = '0;
      if (ga >= 0) e_rdy[ga] = 1'b1;
      if (gb >= 0) e_rdy[gb] = 1'b1;

      chk("ready", 64'(req_ready_o), 64'(e_rdy));
      chk("enA",   64'(enA_o),   64'(ga >= 0));
      chk("weA",   64'(weA_o),   (ga >= 0) ? 64'(req_we_i[ga]) : 64'd0);
      chk("addrA", 64'(addrA_o), (ga >= 0) ? 64'(addr_of(ga)) : 64'd0);
      chk("dA",    64'(dA_o),    (ga >= 0 && req_we_i[ga]) ? 64'(data_of(ga)) :
                                 (ga >= 0) ? 64'(data_of(ga)) : 64'd0);
      chk("enB",   64'(enB_o),   64'(gb >= 0));
      chk("weB",   64'(weB_o),   (gb >= 0) ? 64'(req_we_i[gb]) : 64'd0);
      chk("addrB", 64'(addrB_o), (gb >= 0) ? 64'(addr_of(gb)) : 64'd0);
      chk("dB",    64'(dB_o),    (gb >= 0) ? 64'(data_of(gb)) : 64'd0);
      chk("rsp_valid", 64'(rsp_valid_o), arst_n_i ? 64'(m_rsp_v) : 64'd0);
      chk("rsp_rdata", 64'(rsp_rdata_o), arst_n_i ? 64'(m_rsp_d) : 64'd0);

      n_v = '0;
      n_d = '0;
      if (ga >= 0 && !req_we_i[ga]) begin
         n_v[ga] = 1'b1;
         n_d[ga*DW +: DW] = m_mem[addr_of(ga)];
      end
      if (gb >= 0 && !req_we_i[gb]) begin
         n_v[gb] = 1'b1;
         n_d[gb*DW +: DW] = m_mem[addr_of(gb)];
      end
      if (ga >= 0 && req_we_i[ga]) m_mem[addr_of(ga)] = data_of(ga);
      if (gb >= 0 && req_we_i[gb]) m_mem[addr_of(gb)] = data_of(gb);
      if (!arst_n_i)    m_rr = 0;
      else if (gb >= 0) m_rr = (gb + 1) % N;
      else if (ga >= 0) m_rr = (ga + 1) % N;
      m_rsp_v = n_v;
      m_rsp_d = n_d;
      m_acc   = e_rdy;
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      arst_n_i = 1'b0;
      clear_all();
      eval();
      nxt();
      arst_n_i = 1'b1;
   endtask

   initial begin
      req_valid_i = '0;
      req_we_i    = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;

      // Reset held with all requesters valid: nothing granted.
      for (int i = 0; i < N; i++) set_req(i, 1, 0, i, 0);
      eval();
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_en", 64'({enA_o, enB_o}), 64'd0);
      chk("rst_rsp", 64'(rsp_valid_o), 64'd0);
      nxt();
      arst_n_i = 1'b1;
      eval();
      chk("first_ready", 64'(req_ready_o), 64'h3);
      chk("first_addrA", 64'(addrA_o), 64'd0);
      chk("first_addrB", 64'(addrB_o), 64'd1);
      nxt();
      eval();
      chk("second_ready", 64'(req_ready_o), 64'hC);
      nxt();
      clear_all();
      eval();
      nxt();

      // Write then read back through requester 2.
      set_req(2, 1, 1, 3, 8'h5A);
      eval();
      chk("wr_ready", 64'(req_ready_o), 64'h4);
      chk("wr_weA", 64'(weA_o), 64'd1);
      nxt();
      set_req(2, 1, 0, 3, 0);
      eval();
      chk("rd_ready", 64'(req_ready_o), 64'h4);
      nxt();
      clear_all();
      eval();
      chk("rd_valid", 64'(rsp_valid_o), 64'h4);
      chk("rd_data", 64'(rsp_rdata_o), 64'h005A0000);
      nxt();

      // Write/read conflict on the same address: write first, read next cycle.
      do_reset();
      set_req(0, 1, 1, 7, 8'hC3);
      set_req(1, 1, 0, 7, 0);
      eval();
      chk("conf_ready", 64'(req_ready_o), 64'h1);
      nxt();
      set_req(0, 0, 0, 0, 0);
      eval();
      chk("conf_ready2", 64'(req_ready_o), 64'h2);
      chk("conf_enA", 64'(enA_o), 64'd1);
      chk("conf_addrA", 64'(addrA_o), 64'd7);
      chk("conf_enB", 64'(enB_o), 64'd0);
      nxt();
      clear_all();
      eval();
      chk("conf_rsp", 64'(rsp_valid_o), 64'h2);
      chk("conf_data", 64'(rsp_rdata_o), 64'h0000C300);
      nxt();

      // Two reads of the same address are granted together.
      set_req(0, 1, 1, 5, 8'h33);
      eval();
      nxt();
      clear_all();
      set_req(1, 1, 0, 5, 0);
      set_req(3, 1, 0, 5, 0);
      eval();
      chk("dual_ready", 64'(req_ready_o), 64'hA);
      nxt();
      clear_all();
      eval();
      chk("dual_rsp", 64'(rsp_valid_o), 64'hA);
      chk("dual_data", 64'(rsp_rdata_o), 64'h33003300);
      nxt();

      // Fairness: everyone reading continuously.
      do_reset();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) set_req(i, 1, 0, i + 8, 0);
         eval();
         chk("fair_pair", 64'(req_ready_o), (c % 2 == 0) ? 64'h3 : 64'hC);
         for (int i = 0; i < N; i++) cnt[i] += int'(rsp_valid_o[i]);
         nxt();
      end
      clear_all();
      eval();
      for (int i = 0; i < N; i++) cnt[i] += int'(rsp_valid_o[i]);
      nxt();
      for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'd4);

      // Reset while a response is in flight.
      do_reset();
      set_req(2, 1, 0, 3, 0);
      eval();
      chk("mid_ready", 64'(req_ready_o), 64'h4);
      nxt();
      clear_all();
      chk("mid_rsp_pre", 64'(rsp_valid_o), 64'h4);
      arst_n_i = 1'b0;
      #1;
      chk("mid_rsp_drop", 64'(rsp_valid_o), 64'd0);
      eval();
      nxt();
      arst_n_i = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1, 0, i, 0);
      eval();
      chk("mid_restart", 64'(req_ready_o), 64'h3);
      nxt();

      // Randomized traffic; requests are held until accepted.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid_i[i] && $urandom_range(0, 99) < 60)
               set_req(i, 1, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 255)));
         end
         eval();
         nxt();
         for (int i = 0; i < N; i++) if (m_acc[i]) set_req(i, 0, 0, 0, 0);
      end
      clear_all();
      eval();
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
